// File: rtl/vector_uop_splitter.sv
// vector_uop_splitter
//   Decodes each queued vector instruction into register-group micro-ops,
//   one per LMUL register. Consumes the instruction queue's valid/pop
//   channel and feeds the issue stage through a registered valid/ready
//   channel. LMUL=1 instructions pass through at one per cycle; larger
//   groups emit one uop per cycle with vd/vs2 (and non-scalar vs1)
//   offset by the uop's position in the group, wrapping modulo 2^RW.
//
// Optional feature macro: UOP_ALIGN_CHECK_EN
//   When defined, a group whose offset operands are not aligned to the
//   group size collapses to a single uop flagged with uop_illegal.
//   When undefined, uop_illegal is tied to 0 and misaligned groups split
//   normally with modulo wrap.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            queue holds an instruction
//   in_pop              consume the queue head this cycle (combinational)
//   in_payload[PW]      opaque opcode/funct bits, copied onto every uop
//   in_vd/vs1/vs2[RW]   base register indices
//   in_vs1_scalar       vs1 is scalar/immediate and never offset
//   in_lmul[2]          group size encoding 0..3 -> 1,2,4,8 registers
//   uop_valid           uop present
//   uop_ready           issue stage accepts the uop
//   uop_payload[PW]     copy of the instruction payload
//   uop_vd/vs1/vs2[RW]  offset register indices
//   uop_idx[3]          position of the uop within the group
//   uop_last            final uop of the instruction
//   uop_illegal         misaligned group (alignment check build only)

module vector_uop_splitter #(
  parameter int unsigned PW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_pop,
  input  logic [PW-1:0] in_payload,
  input  logic [RW-1:0] in_vd,
  input  logic [RW-1:0] in_vs1,
  input  logic [RW-1:0] in_vs2,
  input  logic          in_vs1_scalar,
  input  logic [1:0]    in_lmul,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [PW-1:0] uop_payload,
  output logic [RW-1:0] uop_vd,
  output logic [RW-1:0] uop_vs1,
  output logic [RW-1:0] uop_vs2,
  output logic [2:0]    uop_idx,
  output logic          uop_last,
  output logic          uop_illegal
);

  localparam int unsigned IW = 3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_BUSY  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic          accept;
  logic          advance;

  logic [PW-1:0] payload_q;
  logic [RW-1:0] vd_q;
  logic [RW-1:0] vs1_q;
  logic [RW-1:0] vs2_q;
  logic          vs1_scalar_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] last_idx_q;
  logic          last_q;

  logic [IW-1:0] grp_last_idx;
  logic [IW-1:0] load_last_idx;
  logic          load_illegal;
  logic [IW-1:0] idx_inc;

  // Group size minus one, straight from the LMUL encoding.
  assign grp_last_idx = IW'((4'd1 << in_lmul) - 4'd1);
  assign idx_inc      = idx_q + IW'(1);

`ifdef UOP_ALIGN_CHECK_EN
  logic [RW-1:0] align_mask;
  logic          misaligned;
  logic          illegal_q;

  // Any set bit below the group size in an offset operand is misaligned.
  assign align_mask   = RW'(grp_last_idx);
  assign misaligned   = (|(in_vd & align_mask)) | (|(in_vs2 & align_mask)) |
                        (~in_vs1_scalar & (|(in_vs1 & align_mask)));
  assign load_last_idx = misaligned ? '0 : grp_last_idx;
  assign load_illegal  = misaligned;
  assign uop_illegal   = illegal_q;
`else
  assign load_last_idx = grp_last_idx;
  assign load_illegal  = 1'b0;
  assign uop_illegal   = 1'b0;
`endif

  assign uop_valid   = (state_q == S_BUSY);
  assign accept      = uop_valid & uop_ready;

  assign uop_payload = payload_q;
  assign uop_vd      = vd_q;
  assign uop_vs1     = vs1_q;
  assign uop_vs2     = vs2_q;
  assign uop_idx     = idx_q;
  assign uop_last    = last_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, queue pop and in-group advance; pop only depends on
  // in_valid, uop_ready, rst and state so there is no data-input path.
  always_comb begin
    state_d = state_q;
    in_pop  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (in_valid && !rst) begin
          in_pop  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept) begin
          if (last_q) begin
            if (in_valid && !rst) begin
              in_pop = 1'b1;
            end else begin
              state_d = S_EMPTY;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output stage: load a fresh instruction on pop, otherwise step the
  // offset indices incrementally so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q    <= '0;
      vd_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vs1_scalar_q <= 1'b0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      last_q       <= 1'b0;
    end else if (in_pop) begin
      payload_q    <= in_payload;
      vd_q         <= in_vd;
      vs1_q        <= in_vs1;
      vs2_q        <= in_vs2;
      vs1_scalar_q <= in_vs1_scalar;
      idx_q        <= '0;
      last_idx_q   <= load_last_idx;
      last_q       <= (load_last_idx == '0);
    end else if (advance) begin
      vd_q         <= vd_q + RW'(1);
      vs2_q        <= vs2_q + RW'(1);
      vs1_q        <= vs1_scalar_q ? vs1_q : vs1_q + RW'(1);
      idx_q        <= idx_inc;
      last_q       <= (idx_inc == last_idx_q);
    end
  end

`ifdef UOP_ALIGN_CHECK_EN
  // Illegal flag travels with the loaded instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (in_pop) begin
      illegal_q <= load_illegal;
    end
  end
`else
  // Keep the load-side signal referenced in the unchecked build.
  logic unused_ok;
  assign unused_ok = load_illegal;
`endif

endmodule

// File: tb/tb_vector_uop_splitter.sv
// Self-checking bench for vector_uop_splitter: a scoreboard of expected
// uops filled on every observed pop and compared while uops are presented.
module tb_vector_uop_splitter;

  localparam int unsigned PW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_pop;
  logic [PW-1:0] in_payload = '0;
  logic [RW-1:0] in_vd = '0;
  logic [RW-1:0] in_vs1 = '0;
  logic [RW-1:0] in_vs2 = '0;
  logic          in_vs1_scalar = 1'b0;
  logic [1:0]    in_lmul = '0;
  logic          uop_valid;
  logic          uop_ready = 1'b1;
  logic [PW-1:0] uop_payload;
  logic [RW-1:0] uop_vd;
  logic [RW-1:0] uop_vs1;
  logic [RW-1:0] uop_vs2;
  logic [2:0]    uop_idx;
  logic          uop_last;
  logic          uop_illegal;

  vector_uop_splitter #(.PW(PW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pop(in_pop), .in_payload(in_payload),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_vs1_scalar(in_vs1_scalar), .in_lmul(in_lmul),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_payload(uop_payload),
    .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
    .uop_idx(uop_idx), .uop_last(uop_last), .uop_illegal(uop_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] payload;
    logic [RW-1:0] vd;
    logic [RW-1:0] vs1;
    logic [RW-1:0] vs2;
    logic [2:0]    idx;
    logic          last;
    logic          illegal;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected uops for one instruction, built from the driven fields.
  task automatic push_expected();
    int   n;
    logic mis;
    logic [RW-1:0] mask;
    exp_t e;
    n    = 1 << in_lmul;
    mask = RW'(n - 1);
    mis  = 1'b0;
`ifdef UOP_ALIGN_CHECK_EN
    mis = ((in_vd & mask) != 0) || ((in_vs2 & mask) != 0) ||
          (!in_vs1_scalar && ((in_vs1 & mask) != 0));
    if (mis) n = 1;
`endif
    for (int i = 0; i < n; i++) begin
      e.payload = in_payload;
      e.vd      = RW'(in_vd + RW'(i));
      e.vs2     = RW'(in_vs2 + RW'(i));
      e.vs1     = in_vs1_scalar ? in_vs1 : RW'(in_vs1 + RW'(i));
      e.idx     = 3'(i);
      e.last    = (i == n - 1);
      e.illegal = mis;
      sb.push_back(e);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic exp_pop;
    exp_t e;
    if (rst) begin
      check_eq("pop_in_rst", 64'(in_pop), 64'(0));
      sb.delete();
    end else begin
      exp_pop = in_valid && ((sb.size() == 0) || (uop_ready && sb[0].last));
      check_eq("in_pop", 64'(in_pop), 64'(exp_pop));
      check_eq("uop_valid", 64'(uop_valid), 64'(sb.size() != 0));
      if (uop_valid && sb.size() != 0) begin
        e = sb[0];
        check_eq("payload", 64'(uop_payload), 64'(e.payload));
        check_eq("vd",      64'(uop_vd),      64'(e.vd));
        check_eq("vs1",     64'(uop_vs1),     64'(e.vs1));
        check_eq("vs2",     64'(uop_vs2),     64'(e.vs2));
        check_eq("idx",     64'(uop_idx),     64'(e.idx));
        check_eq("last",    64'(uop_last),    64'(e.last));
        check_eq("illegal", 64'(uop_illegal), 64'(e.illegal));
        if (uop_ready) void'(sb.pop_front());
      end
      if (in_pop) push_expected();
    end
  end

  // Ready pattern, changed just after the active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       uop_ready = 1'b1;
      1:       uop_ready = ~uop_ready;
      default: uop_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic wait_pop();
    bit got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_pop) begin
        got = 1;
        break;
      end
    end
    if (!got) check_eq("pop_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [RW-1:0] vd,
                      input logic [RW-1:0] vs1, input logic [RW-1:0] vs2,
                      input logic sc, input logic [1:0] lmul);
    in_payload    = p;
    in_vd         = vd;
    in_vs1        = vs1;
    in_vs2        = vs2;
    in_vs1_scalar = sc;
    in_lmul       = lmul;
    in_valid      = 1'b1;
    wait_pop();
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !uop_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) check_eq("idle_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check_eq("rst_valid",   64'(uop_valid),   64'(0));
    check_eq("rst_pop",     64'(in_pop),      64'(0));
    check_eq("rst_payload", 64'(uop_payload), 64'(0));
    check_eq("rst_vd",      64'(uop_vd),      64'(0));
    check_eq("rst_vs1",     64'(uop_vs1),     64'(0));
    check_eq("rst_vs2",     64'(uop_vs2),     64'(0));
    check_eq("rst_idx",     64'(uop_idx),     64'(0));
    check_eq("rst_last",    64'(uop_last),    64'(0));
    check_eq("rst_illegal", 64'(uop_illegal), 64'(0));
    rst = 1'b0;

    // LMUL=1 stream, back to back.
    send(32'h1111_0001, 5'd1, 5'd2, 5'd3, 1'b0, 2'd0);
    send(32'h1111_0002, 5'd4, 5'd5, 5'd6, 1'b0, 2'd0);
    send(32'h1111_0003, 5'd7, 5'd8, 5'd9, 1'b1, 2'd0);

    // LMUL=4 group, followed immediately by another instruction.
    send(32'h2222_0000, 5'd8, 5'd4, 5'd16, 1'b0, 2'd2);
    send(32'h2222_0001, 5'd0, 5'd1, 5'd2, 1'b0, 2'd1);
    wait_idle();

    // LMUL=8 with scalar vs1 and ready toggling every cycle.
    rdy_mode = 1;
    send(32'h3333_0000, 5'd24, 5'd7, 5'd8, 1'b1, 2'd3);
    send(32'h3333_0001, 5'd16, 5'd9, 5'd0, 1'b0, 2'd2);
    wait_idle();
    rdy_mode = 0;

    // Misaligned group: wraps, or collapses to one illegal uop.
    send(32'h4444_0000, 5'd30, 5'd0, 5'd4, 1'b0, 2'd2);
    wait_idle();

    // Reset mid-group at idx 2 with the next instruction already queued.
    send(32'h5555_0000, 5'd0, 5'd8, 5'd16, 1'b0, 2'd3);
    in_payload = 32'h5555_0001; in_vd = 5'd2; in_vs1 = 5'd3; in_vs2 = 5'd4;
    in_vs1_scalar = 1'b0; in_lmul = 2'd1; in_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uop_valid && uop_idx == 3'd1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check_eq("idx1_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_valid", 64'(uop_valid), 64'(0));
    check_eq("midrst_pop",   64'(in_pop),    64'(0));
    check_eq("midrst_idx",   64'(uop_idx),   64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_pop();
    wait_idle();

    // Idle gap, then a late instruction.
    repeat (3) @(posedge clk);
    #1;
    send(32'h6666_0000, 5'd12, 5'd1, 5'd20, 1'b1, 2'd2);
    wait_idle();

    // Random traffic under random back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      send($urandom, RW'($urandom), RW'($urandom), RW'($urandom),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    wait_idle();
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
